muller_c_arbiter: RTL and testbench

MULLER_C_ARBITER -- requirements
Module: muller_c_arbiter

---
 rtl/muller_c_pkg.sv | 24 ++
 rtl/muller_c_sync2.sv | 31 +++
 rtl/muller_c_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_muller_c_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muller_c_pkg.sv
// Shared types and defaults for the Muller C-element test arbiter.
package muller_c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_APPLY   = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Round-robin pick between two requesters; on a tie the one not granted
  // last wins. Result is meaningless when req is 2'b00.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return ~last;
  endfunction

endpackage

// File: rtl/muller_c_sync2.sv
// Two-flop synchronizer for the asynchronous C-element output.
module muller_c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next-value logic for the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer flops, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/muller_c_arbiter.sv
// Two-requester round-robin arbiter sharing one Muller C-element.
// Optional build macro MULLER_C_ARB_TIMEOUT_EN adds a watchdog on the
// CLEAR and RELEASE waits; without it those waits are unbounded.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | C inputs 00, waiting for a request, arbitrates
// CLEAR   | C inputs 00, waiting for synchronized output to read 0
// APPLY   | latched operands on the C inputs for SETTLE_CYCLES+2 cycles
// SAMPLE  | capture synchronized output and compare against expected
// RELEASE | C inputs 00, waiting for synchronized output to read 0
// DONE    | one-cycle done pulse to the granted requester
module muller_c_arbiter
  import muller_c_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [1:0] grant_o,
  output logic [1:0] done_o,
  output logic       result_o,
  output logic       mismatch_o,
  output logic       ce_a_o,
  output logic       ce_b_o,
  input  logic       ce_c_i,
  output logic       timeout_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_range
    $error("SETTLE_CYCLES must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  // APPLY lasts load+1 cycles because the terminal count cycle is included
  localparam logic [8:0] APPLY_LOAD = 9'(SETTLE_CYCLES + 1);

  logic c_s;

  muller_c_sync2 u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (ce_c_i),
    .q   (c_s)
  );

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       op_a_q, op_a_d;
  logic       op_b_q, op_b_d;
  logic       expected_q, expected_d;
  logic       result_q, result_d;
  logic       mismatch_q, mismatch_d;
  logic [8:0] apply_cnt_q, apply_cnt_d;
  logic       win;

`ifdef MULLER_C_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // next-state, arbitration and sample logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    expected_d  = expected_q;
    result_d    = result_q;
    mismatch_d  = mismatch_q;
    apply_cnt_d = apply_cnt_q;
    win         = rr_pick(req_i, last_q);
`ifdef MULLER_C_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_d    = win ? 2'b10 : 2'b01;
          last_d     = win;
          op_a_d     = a_i[win];
          op_b_d     = b_i[win];
          // C output starts cleared, so unequal operands leave it at 0
          expected_d = a_i[win] & b_i[win];
          state_d    = ST_CLEAR;
`ifdef MULLER_C_ARB_TIMEOUT_EN
          tmo_cnt_d  = TMO_LOAD;
`endif
        end
      end
      ST_CLEAR: begin
        if (!c_s) begin
          state_d     = ST_APPLY;
          apply_cnt_d = APPLY_LOAD;
        end
`ifdef MULLER_C_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 16'd0) begin
          timeout_d  = 1'b1;
          mismatch_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 16'd1;
        end
`endif
      end
      ST_APPLY: begin
        if (apply_cnt_q == 9'd0) state_d = ST_SAMPLE;
        else                     apply_cnt_d = apply_cnt_q - 9'd1;
      end
      ST_SAMPLE: begin
        result_d   = c_s;
        mismatch_d = c_s != expected_q;
        state_d    = ST_RELEASE;
`ifdef MULLER_C_ARB_TIMEOUT_EN
        tmo_cnt_d  = TMO_LOAD;
`endif
      end
      ST_RELEASE: begin
        if (!c_s) state_d = ST_DONE;
`ifdef MULLER_C_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == 16'd0) begin
          timeout_d  = 1'b1;
          mismatch_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 16'd1;
        end
`endif
      end
      ST_DONE: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers; reset leaves requester 1 as last granted
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      op_a_q      <= 1'b0;
      op_b_q      <= 1'b0;
      expected_q  <= 1'b0;
      result_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      apply_cnt_q <= 9'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      expected_q  <= expected_d;
      result_q    <= result_d;
      mismatch_q  <= mismatch_d;
      apply_cnt_q <= apply_cnt_d;
    end
  end

`ifdef MULLER_C_ARB_TIMEOUT_EN
  // watchdog counter and sticky timeout flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_o    = grant_q;
  assign done_o     = (state_q == ST_DONE) ? grant_q : 2'b00;
  assign result_o   = result_q;
  assign mismatch_o = mismatch_q;
  assign ce_a_o     = (state_q == ST_APPLY) & op_a_q;
  assign ce_b_o     = (state_q == ST_APPLY) & op_b_q;

endmodule

// File: tb/tb_muller_c_arbiter.sv
// Randomized self-checking bench for muller_c_arbiter with a behavioural
// C-element (3-cycle output delay, optional stuck-at faults).
module tb_muller_c_arbiter;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 8;
  localparam int APPLY_LEN = SETTLE + 2;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [1:0] req_i = 2'b00;
  logic [1:0] a_i = 2'b00;
  logic [1:0] b_i = 2'b00;
  logic [1:0] grant_o, done_o;
  logic       result_o, mismatch_o, ce_a_o, ce_b_o, ce_c_i, timeout_o;

  int n_checks = 0;
  int n_errs   = 0;
  int model_last = 1;
  int grant_log[$];

  logic       c_true = 1'b0;
  logic [1:0] c_pipe = 2'b00;
  bit         c_stuck0 = 1'b0;
  bit         c_stuck1 = 1'b0;

  always #5 clk = ~clk;

  muller_c_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .req_i      (req_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .grant_o    (grant_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .mismatch_o (mismatch_o),
    .ce_a_o     (ce_a_o),
    .ce_b_o     (ce_b_o),
    .ce_c_i     (ce_c_i),
    .timeout_o  (timeout_o)
  );

  // behavioural C-element: output follows when inputs agree, holds otherwise
  always @(posedge clk) begin
    if (ce_a_o && ce_b_o)        c_true <= 1'b1;
    else if (!ce_a_o && !ce_b_o) c_true <= 1'b0;
    c_pipe <= {c_pipe[0], c_true};
  end
  assign ce_c_i = c_stuck1 ? 1'b1 : (c_stuck0 ? 1'b0 : c_pipe[1]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    wb_rst_i = 1'b1;
    req_i = 2'b00;
    repeat (cycles) @(negedge clk);
    wb_rst_i = 1'b0;
    model_last = 1;
  endtask

  // One transaction from the requester-side view, checked against a model
  // derived from the arbitration and C-element rules.
  task automatic txn(input logic [1:0] req, input logic [1:0] a, input logic [1:0] b,
                     input bit drop, input bit hold);
    int  w;
    bit  got;
    bit  grant_bad;
    int  ce_cnt;
    logic [1:0] ce_seen;
    logic ea, eb, eres, emis;
    req_i = req;
    a_i = a;
    b_i = b;
    if (req == 2'b01)      w = 0;
    else if (req == 2'b10) w = 1;
    else                   w = (model_last == 1) ? 0 : 1;
    model_last = w;
    ea = a[w];
    eb = b[w];
    eres = c_stuck0 ? 1'b0 : (ea & eb);
    emis = eres != (ea & eb);

    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (grant_o != 2'b00) got = 1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant_value", 32'(grant_o), 32'd1 << w);
    grant_log.push_back(w);
    a_i = 2'($urandom);
    b_i = 2'($urandom);

    got = 0;
    grant_bad = 0;
    ce_cnt = 0;
    ce_seen = 2'b00;
    for (int k = 0; k < 200 && !got; k++) begin
      if (done_o != 2'b00) got = 1;
      else begin
        if (grant_o != (2'b01 << w)) grant_bad = 1;
        if (ce_a_o || ce_b_o) ce_cnt++;
        ce_seen = ce_seen | {ce_a_o, ce_b_o};
        @(negedge clk);
        if (k == 0 && drop) req_i = 2'b00;
      end
    end
    chk("grant_hold", 32'(grant_bad), 32'd0);
    chk("done_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("done_value", 32'(done_o), 32'd1 << w);
    chk("result", 32'(result_o), 32'(eres));
    chk("mismatch", 32'(mismatch_o), 32'(emis));
    chk("ce_operands", 32'(ce_seen), 32'({ea, eb}));
    chk("apply_len", 32'(ce_cnt), (ea | eb) ? 32'(APPLY_LEN) : 32'd0);
    req_i = hold ? req : 2'b00;
    @(negedge clk);
    chk("grant_clear", 32'(grant_o), 32'd0);
    chk("done_pulse", 32'(done_o), 32'd0);
  endtask

  initial begin
    bit got;
    int k;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_outs", 32'({result_o, mismatch_o, ce_a_o, ce_b_o, timeout_o}), 32'd0);
    wb_rst_i = 1'b0;
    model_last = 1;
    @(negedge clk);

    // directed: matching ones on requester 0, unequal operands on requester 1
    txn(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
    txn(2'b10, 2'b10, 2'b00, 1'b0, 1'b0);

    // held tie from reset alternates 0,1,0
    do_reset(2);
    grant_log.delete();
    for (int i = 0; i < 3; i++)
      txn(2'b11, 2'($urandom), 2'($urandom), 1'b0, i < 2);
    if (grant_log.size() == 3) begin
      chk("rr_order0", 32'(grant_log[0]), 32'd0);
      chk("rr_order1", 32'(grant_log[1]), 32'd1);
      chk("rr_order2", 32'(grant_log[2]), 32'd0);
    end else begin
      chk("rr_order_len", 32'(grant_log.size()), 32'd3);
    end

    // request dropped one cycle after grant still completes
    txn(2'b10, 2'b11, 2'b11, 1'b1, 1'b0);
    txn(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);

    // reset during APPLY aborts without done
    req_i = 2'b01;
    a_i = 2'b01;
    b_i = 2'b01;
    got = 0;
    for (k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (ce_a_o) got = 1;
    end
    chk("apply_reached", 32'(got), 32'd1);
    wb_rst_i = 1'b1;
    req_i = 2'b00;
    @(negedge clk);
    wb_rst_i = 1'b0;
    model_last = 1;
    chk("abort_grant", 32'(grant_o), 32'd0);
    chk("abort_outs", 32'({done_o, result_o, mismatch_o, ce_a_o, ce_b_o, timeout_o}), 32'd0);
    got = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_o != 2'b00) got = 1;
    end
    chk("abort_no_done", 32'(got), 32'd0);
    txn(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);

    // randomized traffic, occasionally with a stuck-at-0 C-element
    for (int i = 0; i < 24; i++) begin
      c_stuck0 = ($urandom_range(0, 4) == 0);
      txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      req_i = 2'b00;
      c_stuck0 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    do_reset(2);
    repeat (6) @(negedge clk);

    // C-element stuck at 1
    c_stuck1 = 1'b1;
    repeat (4) @(negedge clk);
    req_i = 2'b01;
    a_i = 2'b01;
    b_i = 2'b01;
    got = 0;
    for (k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (grant_o != 2'b00) got = 1;
    end
    chk("stuck_grant", 32'(got), 32'd1);
`ifdef MULLER_C_ARB_TIMEOUT_EN
    got = 0;
    for (k = 0; k < 30 && !got; k++) begin
      if (done_o != 2'b00) got = 1;
      else @(negedge clk);
    end
    chk("tmo_done_seen", 32'(got), 32'd1);
    chk("tmo_within", 32'(k <= TIMEOUT + 1), 32'd1);
    chk("tmo_done_value", 32'(done_o), 32'd1);
    chk("tmo_flag", 32'(timeout_o), 32'd1);
    chk("tmo_mismatch", 32'(mismatch_o), 32'd1);
    chk("tmo_ce_idle", 32'({ce_a_o, ce_b_o}), 32'd0);
    req_i = 2'b00;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", 32'(timeout_o), 32'd1);
`else
    got = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o != 2'b00) got = 1;
    end
    chk("stuck_no_done", 32'(got), 32'd0);
    chk("stuck_grant_held", 32'(grant_o), 32'd1);
    chk("stuck_no_tmo", 32'(timeout_o), 32'd0);
    chk("stuck_ce_idle", 32'({ce_a_o, ce_b_o}), 32'd0);
`endif
    c_stuck1 = 1'b0;
    do_reset(2);
    chk("post_rst_tmo", 32'(timeout_o), 32'd0);
    repeat (6) @(negedge clk);
    txn(2'b10, 2'b10, 2'b10, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
